// File: rtl/dds_spi_master.sv
// SPI mode-0 master for the DDS tuning-register link: one 24-bit frame per start,
// frame = {reg_sel, 6'b0, wdata}, MSB first, every output driven straight from a flop.
module dds_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  reg_sel,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        spi_clock,
  output logic        spi_cs_n,
  output logic        spi_mosi
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP, DONE_S
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick;
  logic          tick_end;
  logic [4:0]    bit_cnt;
  logic [23:0]   shreg;
  logic          accept;
  logic          busy_d, done_d, clock_d, cs_n_d, mosi_d;

  // A start is only honoured in IDLE or the final DONE cycle, which allows back-to-back frames.
  assign accept   = start && ((state == IDLE) || (state == DONE_S));
  assign tick_end = (tick == TW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SETUP;
      SETUP:   if (tick_end) state_nxt = SCK_HI;
      SCK_HI:  if (tick_end) state_nxt = SCK_LO;
      SCK_LO:  if (tick_end) state_nxt = (bit_cnt == 5'd0) ? HOLD : SCK_HI;
      HOLD:    if (tick_end) state_nxt = GAP;
      GAP:     if (tick_end) state_nxt = DONE_S;
      DONE_S:  state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick    <= '0;
      bit_cnt <= 5'd0;
    end else begin
      if ((state == IDLE) || (state_nxt != state)) tick <= '0;
      else                                         tick <= tick + TW'(1);
      if (accept)
        bit_cnt <= 5'd23;
      else if ((state == SCK_LO) && tick_end && (bit_cnt != 5'd0))
        bit_cnt <= bit_cnt - 5'd1;
    end
  end

  // Shifting at the end of SCK_HI presents the next bit together with the falling edge.
  always_ff @(posedge clk) begin
    if (accept)
      shreg <= {reg_sel, 6'b000000, wdata};
    else if ((state == SCK_HI) && tick_end)
      shreg <= {shreg[22:0], 1'b0};
  end

  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    clock_d = 1'b0;
    cs_n_d  = 1'b1;
    mosi_d  = 1'b0;
    case (state)
      SETUP, SCK_HI, SCK_LO: begin
        busy_d  = 1'b1;
        cs_n_d  = 1'b0;
        mosi_d  = shreg[23];
        clock_d = (state == SCK_HI);
      end
      HOLD: begin
        busy_d = 1'b1;
        cs_n_d = 1'b0;
      end
      GAP:     busy_d = 1'b1;
      DONE_S:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Output stage: pins are the registered decode of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_clock <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      spi_clock <= clock_d;
      spi_cs_n  <= cs_n_d;
      spi_mosi  <= mosi_d;
    end
  end

endmodule

// File: tb/tb_dds_spi_master.sv
// Bench for dds_spi_master: three instances (CLK_DIV 4, 2, 1) sharing clk/rst, an SPI slave
// model feeding a frame scoreboard, and a per-cycle event recorder for frame timing.
module tb_dds_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic [1:0]  rs_v    [3];
  logic [15:0] wd_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        sclk_v  [3];
  logic        cs_v    [3];
  logic        mosi_v  [3];
  logic [1:0]  sel = 2'd0;

  always #5 clk = ~clk;

  dds_spi_master #(.CLK_DIV(4)) u_d4 (.clk(clk), .rst(rst), .start(start_v[0]), .reg_sel(rs_v[0]),
    .wdata(wd_v[0]), .busy(busy_v[0]), .done(done_v[0]), .spi_clock(sclk_v[0]),
    .spi_cs_n(cs_v[0]), .spi_mosi(mosi_v[0]));
  dds_spi_master #(.CLK_DIV(2)) u_d2 (.clk(clk), .rst(rst), .start(start_v[1]), .reg_sel(rs_v[1]),
    .wdata(wd_v[1]), .busy(busy_v[1]), .done(done_v[1]), .spi_clock(sclk_v[1]),
    .spi_cs_n(cs_v[1]), .spi_mosi(mosi_v[1]));
  dds_spi_master #(.CLK_DIV(1)) u_d1 (.clk(clk), .rst(rst), .start(start_v[2]), .reg_sel(rs_v[2]),
    .wdata(wd_v[2]), .busy(busy_v[2]), .done(done_v[2]), .spi_clock(sclk_v[2]),
    .spi_cs_n(cs_v[2]), .spi_mosi(mosi_v[2]));

  logic m_clk, m_cs, m_mosi, m_busy, m_done;
  assign m_clk  = sclk_v[sel];
  assign m_cs   = cs_v[sel];
  assign m_mosi = mosi_v[sel];
  assign m_busy = busy_v[sel];
  assign m_done = done_v[sel];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: expected frames pushed when a start is driven, popped when CS closes a 24-bit frame.
  logic [23:0] exp_q[$];
  logic [23:0] sh = '0;
  int          nb = 0;
  int          frames_rx = 0;

  always @(posedge m_clk) if (!m_cs) begin
    sh = {sh[22:0], m_mosi};
    nb++;
  end

  always @(posedge m_cs) begin
    if (nb == 24) begin
      frames_rx++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_frame actual=%0h required=none", sh);
      end else begin
        chk("frame", {8'h0, sh}, {8'h0, exp_q.pop_front()});
      end
    end
    nb = 0;
  end

  // Per-cycle recorder, sampled 1 time unit after each rising clk edge; times relative to t0.
  int   cyc = 0, t0 = 0;
  int   t_csfall, t_rise0, t_csrise, t_done, t_busy, n_rise, n_done, mosi_viol, edge_viol;
  logic p_cs = 1'b1, p_clk = 1'b0, p_mosi = 1'b0, p_done = 1'b0, p_busy = 1'b0;

  task automatic clr_frame();
    t_csfall = -1; t_rise0 = -1; t_csrise = -1; t_done = -1; t_busy = -1;
    n_rise = 0; n_done = 0; mosi_viol = 0; edge_viol = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (p_cs && !m_cs && t_csfall < 0) t_csfall = cyc - t0;
    if (!p_cs && m_cs && t_csrise < 0) t_csrise = cyc - t0;
    if (!p_busy && m_busy && t_busy < 0) t_busy = cyc - t0;
    if (!p_clk && m_clk) begin
      n_rise++;
      if (t_rise0 < 0) t_rise0 = cyc - t0;
    end
    if (m_done && !p_done) begin
      n_done++;
      if (t_done < 0) t_done = cyc - t0;
    end
    if (m_mosi !== p_mosi && !m_cs && !(p_clk && !m_clk) && !(p_cs && !m_cs)) mosi_viol++;
    if (m_clk !== p_clk && m_cs && p_cs) edge_viol++;
    p_cs = m_cs; p_clk = m_clk; p_mosi = m_mosi; p_done = m_done; p_busy = m_busy;
  end

  task automatic send(input logic [1:0] di, input logic [1:0] rs, input logic [15:0] wd,
                      input logic [23:0] frame);
    @(negedge clk);
    sel = di;
    rs_v[di] = rs;
    wd_v[di] = wd;
    start_v[di] = 1'b1;
    exp_q.push_back(frame);
    t0 = cyc + 1;
    clr_frame();
    @(negedge clk);
    start_v[di] = 1'b0;
    rs_v[di] = ~rs;
    wd_v[di] = ~wd;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", n_done, 1);
  endtask

  typedef struct {
    logic [1:0]  di;
    int          div;
    logic [1:0]  rs;
    logic [15:0] wd;
    logic [23:0] frame;
    int          done_at;
    int          rise0_at;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad;
    int t0a, t0b, csrise_a;
    vecs[0] = '{di: 2'd1, div: 2, rs: 2'b01, wd: 16'hA5C3, frame: 24'h40A5C3, done_at: 103, rise0_at: 3};
    vecs[1] = '{di: 2'd2, div: 1, rs: 2'b11, wd: 16'hFFFF, frame: 24'hC0FFFF, done_at: 52, rise0_at: 2};
    vecs[2] = '{di: 2'd0, div: 4, rs: 2'b10, wd: 16'h1234, frame: 24'h801234, done_at: 205, rise0_at: 5};
    vecs[3] = '{di: 2'd1, div: 2, rs: 2'b00, wd: 16'h0001, frame: 24'h000001, done_at: 103, rise0_at: 3};
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; rs_v[i] = 2'b00; wd_v[i] = 16'h0000;
    end
    clr_frame();

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("reset_pins", {27'h0, m_cs, m_clk, m_mosi, m_busy, m_done}, 32'b10000);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({m_cs, m_clk, m_mosi, m_busy, m_done} !== 5'b10000) bad++;
    end
    chk("idle_toggles", bad, 0);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].di, vecs[i].rs, vecs[i].wd, vecs[i].frame);
      wait_done(60 * vecs[i].div + 20);
      chk("cs_fall", t_csfall, 1);
      chk("busy_rise", t_busy, 1);
      chk("rise0", t_rise0, vecs[i].rise0_at);
      chk("rise_count", n_rise, 24);
      chk("cs_rise", t_csrise, 1 + 50 * vecs[i].div);
      chk("done_at", t_done, vecs[i].done_at);
      chk("mosi_stable", mosi_viol, 0);
      chk("edge_outside_cs", edge_viol, 0);
      repeat (5) @(negedge clk);
    end

    // Back-to-back: second start lands in the DONE state cycle of the first frame
    send(2'd1, 2'b10, 16'h1234, 24'h801234);
    t0a = t0;
    while (cyc < t0a + 51 * 2) @(negedge clk);
    rs_v[1] = 2'b00; wd_v[1] = 16'h0001; start_v[1] = 1'b1;
    exp_q.push_back(24'h000001);
    @(negedge clk);
    start_v[1] = 1'b0;
    t0b = cyc;
    chk("b2b_period", t0b - t0a, 51 * 2 + 1);
    chk("b2b_done1", t_done, 51 * 2 + 1);
    csrise_a = t0a + t_csrise;
    t0 = t0b;
    clr_frame();
    wait_done(150);
    chk("b2b_cs_gap", (t0b + t_csfall) - csrise_a, 2 + 1);
    chk("b2b_rise_count", n_rise, 24);
    repeat (5) @(negedge clk);

    // Start while busy is ignored
    bad = frames_rx;
    send(2'd1, 2'b01, 16'h5A5A, 24'h405A5A);
    while (cyc < t0 + 19) @(negedge clk);
    rs_v[1] = 2'b11; wd_v[1] = 16'hDEAD; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_done(150);
    repeat (150) @(negedge clk);
    chk("busy_start_frames", frames_rx - bad, 1);
    chk("busy_start_dones", n_done, 1);

    // Reset mid-frame, after the 10th rising spi_clock edge, while spi_clock is low
    send(2'd1, 2'b10, 16'hBEEF, 24'h80BEEF);
    begin
      int k = 0;
      while (n_rise < 10 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("rise10_reached", n_rise, 10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset_pins", {27'h0, m_cs, m_clk, m_mosi, m_busy, m_done}, 32'b10000);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", n_done, 0);
    send(2'd1, 2'b01, 16'hC0DE, 24'h40C0DE);
    wait_done(150);
    chk("post_reset_done", t_done, 103);
    chk("post_reset_rises", n_rise, 24);
    repeat (5) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
